// File: rtl/a2d_scheduler.sv
// a2d_scheduler: sweeps four ADC128S channels (0, 2, 5, 7) over SPI on each
// strt_cnv pulse and keeps the latest 12-bit result for each channel.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   strt_cnv   one-cycle pulse, starts a sweep (ignored while busy)
//   MISO       serial data from the ADC
//   SS_n       active-low slave select
//   SCLK       serial clock, clk/32, idles high
//   MOSI       serial command data to the ADC
//   batt       channel 0 result
//   IR_rght    channel 2 result
//   IR_lft     channel 5 result
//   IR_cntr    channel 7 result
//   busy       high from sweep start through the DONE cycle
//   cnv_cmplt  one-cycle pulse when a sweep finishes
module a2d_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] batt,
  output logic [11:0] IR_rght,
  output logic [11:0] IR_lft,
  output logic [11:0] IR_cntr,
  output logic        busy,
  output logic        cnv_cmplt
);

  typedef enum logic [1:0] {StIdle, StXfer, StGap, StDone} state_e;

  // Divider value loaded at SS_n fall; bit 4 set so SCLK starts (and idles) high.
  localparam logic [4:0] DivPreload = 5'b10111;
  localparam logic [4:0] DivRise    = 5'b01111;
  localparam logic [4:0] DivFall    = 5'b11111;
  localparam logic [2:0] LastTxn    = 3'd4;
  localparam logic [4:0] NumBits    = 5'd16;

  state_e      state_q, state_d;
  logic [4:0]  div_q, div_d;
  logic [4:0]  smpl_q, smpl_d;
  logic [2:0]  txn_q, txn_d;
  logic        gap_q, gap_d;
  logic        ss_n_q, ss_n_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] rx_q, rx_d;
  logic [11:0] batt_q, batt_d;
  logic [11:0] rght_q, rght_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] cntr_q, cntr_d;

  // Channel sent in each transaction; T4 resends 7 only to clock out T3's result.
  function automatic logic [2:0] chan_sel(input logic [2:0] idx);
    logic [2:0] ch;
    case (idx)
      3'd0:    ch = 3'd0;
      3'd1:    ch = 3'd2;
      3'd2:    ch = 3'd5;
      default: ch = 3'd7;
    endcase
    return ch;
  endfunction

  function automatic logic [15:0] cmd_word(input logic [2:0] idx);
    return {2'b00, chan_sel(idx), 11'h000};
  endfunction

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    smpl_d  = smpl_q;
    txn_d   = txn_q;
    gap_d   = gap_q;
    ss_n_d  = ss_n_q;
    cmd_d   = cmd_q;
    rx_d    = rx_q;
    batt_d  = batt_q;
    rght_d  = rght_q;
    lft_d   = lft_q;
    cntr_d  = cntr_q;

    unique case (state_q)
      StIdle: begin
        if (strt_cnv) begin
          state_d = StXfer;
          txn_d   = 3'd0;
          ss_n_d  = 1'b0;
          div_d   = DivPreload;
          smpl_d  = 5'd0;
          cmd_d   = cmd_word(3'd0);
        end
      end

      StXfer: begin
        div_d = div_q + 5'd1;
        if (div_q == DivRise) begin
          rx_d   = {rx_q[14:0], MISO};
          smpl_d = smpl_q + 5'd1;
        end
        if (div_q == DivFall) begin
          if (smpl_q == NumBits) begin
            // End of transaction: park SCLK high, drop SS, store the result
            // that belongs to the previous transaction's channel.
            ss_n_d = 1'b1;
            div_d  = DivPreload;
            cmd_d  = 16'h0000;
            gap_d  = 1'b0;
            case (txn_q)
              3'd1:    batt_d = rx_q[11:0];
              3'd2:    rght_d = rx_q[11:0];
              3'd3:    lft_d  = rx_q[11:0];
              3'd4:    cntr_d = rx_q[11:0];
              default: ;
            endcase
            state_d = (txn_q == LastTxn) ? StDone : StGap;
          end else if (smpl_q != 5'd0) begin
            // First fall of a transaction precedes any rise; cmd[15] must stay.
            cmd_d = {cmd_q[14:0], 1'b0};
          end
        end
      end

      StGap: begin
        if (gap_q) begin
          state_d = StXfer;
          txn_d   = txn_q + 3'd1;
          ss_n_d  = 1'b0;
          div_d   = DivPreload;
          smpl_d  = 5'd0;
          cmd_d   = cmd_word(txn_q + 3'd1);
        end else begin
          gap_d = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= DivPreload;
      smpl_q  <= 5'd0;
      txn_q   <= 3'd0;
      gap_q   <= 1'b0;
      ss_n_q  <= 1'b1;
      cmd_q   <= 16'h0000;
      rx_q    <= 16'h0000;
      batt_q  <= 12'h000;
      rght_q  <= 12'h000;
      lft_q   <= 12'h000;
      cntr_q  <= 12'h000;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      smpl_q  <= smpl_d;
      txn_q   <= txn_d;
      gap_q   <= gap_d;
      ss_n_q  <= ss_n_d;
      cmd_q   <= cmd_d;
      rx_q    <= rx_d;
      batt_q  <= batt_d;
      rght_q  <= rght_d;
      lft_q   <= lft_d;
      cntr_q  <= cntr_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = div_q[4];
  assign MOSI      = cmd_q[15];
  assign batt      = batt_q;
  assign IR_rght   = rght_q;
  assign IR_lft    = lft_q;
  assign IR_cntr   = cntr_q;
  assign busy      = (state_q != StIdle);
  assign cnv_cmplt = (state_q == StDone);

endmodule

// File: tb/tb_a2d_scheduler.sv
// tb_a2d_scheduler: randomized scoreboard bench for a2d_scheduler with a
// behavioural ADC128S model. Expected per-transaction snapshots and per-sweep
// results are queued at stimulus time; a negedge monitor pops and compares.
module tb_a2d_scheduler;

  logic        clk, rst, strt_cnv, MISO;
  logic        SS_n, SCLK, MOSI, busy, cnv_cmplt;
  logic [11:0] batt, IR_rght, IR_lft, IR_cntr;

  a2d_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .strt_cnv (strt_cnv),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .batt     (batt),
    .IR_rght  (IR_rght),
    .IR_lft   (IR_lft),
    .IR_cntr  (IR_cntr),
    .busy     (busy),
    .cnv_cmplt(cnv_cmplt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- ADC128S model ----------------
  logic [11:0] adc_val [8];
  logic [15:0] adc_tx, adc_rx;
  int          adc_rises;
  logic [2:0]  adc_prev_ch = 3'd0;

  initial MISO = 1'b0;

  always @(negedge SS_n) begin
    // Result is for the channel addressed in the previous transaction; the
    // upper nibble is junk the DUT must ignore.
    adc_tx    = {4'($urandom), adc_val[adc_prev_ch]};
    adc_rx    = 16'h0000;
    adc_rises = 0;
    MISO      = adc_tx[15];
  end

  always @(posedge SCLK) begin
    if (!SS_n) begin
      adc_rx = {adc_rx[14:0], MOSI};
      adc_rises++;
      if (adc_rises < 16) MISO = adc_tx[15-adc_rises];
    end
  end

  always @(posedge SS_n) begin
    if (adc_rises == 16) adc_prev_ch = adc_rx[13:11];
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [15:0] mosi;
    logic [11:0] b, rr, l, c;
    logic        more;
  } txn_t;

  typedef struct packed {
    logic [11:0] b, rr, l, c;
  } res_t;

  txn_t        txn_q[$];
  res_t        res_q[$];
  logic [11:0] mo [4];  // modelled output registers: batt, IR_rght, IR_lft, IR_cntr

  task automatic push_sweep();
    logic [2:0] chs [5];
    txn_t e;
    res_t r;
    chs = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd7};
    for (int k = 0; k < 5; k++) begin
      // Transaction k returns the reading for the channel sent in k-1.
      if (k > 0) mo[k-1] = adc_val[chs[k-1]];
      e.mosi = {2'b00, chs[k], 11'h000};
      e.b    = mo[0];
      e.rr   = mo[1];
      e.l    = mo[2];
      e.c    = mo[3];
      e.more = (k < 4);
      txn_q.push_back(e);
    end
    r.b  = mo[0];
    r.rr = mo[1];
    r.l  = mo[2];
    r.c  = mo[3];
    res_q.push_back(r);
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   ss_falls = 0;
  int   win_len, high_len, falls, per_bad, last_fall;
  logic prev_ss_n = 1'b1, prev_sclk = 1'b1, gap_chk = 1'b0;

  always @(negedge clk) begin
    txn_t e;
    res_t r;
    cyc++;
    if (rst) begin
      prev_ss_n = 1'b1;
      prev_sclk = 1'b1;
      gap_chk   = 1'b0;
      high_len  = 0;
    end else begin
      if (!SS_n) begin
        if (prev_ss_n) begin
          ss_falls++;
          if (gap_chk) check("ss_high_gap", 32'(high_len), 32'd2);
          gap_chk   = 1'b0;
          win_len   = 0;
          falls     = 0;
          per_bad   = 0;
          last_fall = -1;
        end
        win_len++;
        if (prev_sclk && !SCLK) begin
          falls++;
          if (last_fall >= 0 && (cyc - last_fall) != 32) per_bad++;
          last_fall = cyc;
        end
      end else begin
        if (!prev_ss_n) begin
          if (txn_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_txn: got a transaction, expected none");
          end else begin
            e = txn_q.pop_front();
            check("mosi_word", 32'(adc_rx), 32'(e.mosi));
            check("sclk_falls", 32'(falls), 32'd16);
            check("sclk_period_errs", 32'(per_bad), 32'd0);
            tests++;
            if (win_len < 519 || win_len > 521) begin
              fails++;
              $display("FAIL ss_low_window: got %0d clk, expected 520+-1", win_len);
            end
            check("txn_batt", 32'(batt), 32'(e.b));
            check("txn_IR_rght", 32'(IR_rght), 32'(e.rr));
            check("txn_IR_lft", 32'(IR_lft), 32'(e.l));
            check("txn_IR_cntr", 32'(IR_cntr), 32'(e.c));
            gap_chk = e.more;
          end
          high_len = 0;
        end
        high_len++;
      end
      if (cnv_cmplt) begin
        if (res_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cnv_cmplt: got pulse, expected none");
        end else begin
          r = res_q.pop_front();
          check("done_busy", 32'(busy), 32'd1);
          check("done_batt", 32'(batt), 32'(r.b));
          check("done_IR_rght", 32'(IR_rght), 32'(r.rr));
          check("done_IR_lft", 32'(IR_lft), 32'(r.l));
          check("done_IR_cntr", 32'(IR_cntr), 32'(r.c));
        end
      end
      prev_ss_n = SS_n;
      prev_sclk = SCLK;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk) strt_cnv = 1'b1;
    @(negedge clk) strt_cnv = 1'b0;
  endtask

  task automatic start_sweep();
    push_sweep();
    pulse_start();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 4000 && !(busy == 1'b0 && txn_q.size() == 0 && res_q.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    check("sweep_completes", 32'(n < 4000), 32'd1);
    check("txn_queue_drained", 32'(txn_q.size()), 32'd0);
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (n < 3000 && ss_falls < target) begin
      @(negedge clk);
      n++;
    end
    check("reach_transaction", 32'(ss_falls >= target), 32'd1);
  endtask

  task automatic wait_cnv();
    int n = 0;
    while (n < 4000 && !cnv_cmplt) begin
      @(negedge clk);
      n++;
    end
    check("cnv_cmplt_seen", 32'(cnv_cmplt), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_SS_n"}, 32'(SS_n), 32'd1);
    check({tag, "_SCLK"}, 32'(SCLK), 32'd1);
    check({tag, "_MOSI"}, 32'(MOSI), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cnv_cmplt"}, 32'(cnv_cmplt), 32'd0);
    check({tag, "_outputs"}, 32'({batt, IR_rght, IR_lft, IR_cntr} == 48'h0), 32'd1);
  endtask

  task automatic set_spec_values();
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
    adc_val[0] = 12'hC00;
    adc_val[2] = 12'h123;
    adc_val[5] = 12'hABC;
    adc_val[7] = 12'h7E5;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst      = 1'b1;
    strt_cnv = 1'b0;
    for (int i = 0; i < 4; i++) mo[i] = 12'h000;
    set_spec_values();
    repeat (3) @(negedge clk);
    check_reset_state("in_reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_state("idle_after_reset");

    // Basic sweep with the reference channel values.
    start_sweep();
    wait_idle();

    // strt_cnv during T2 and during DONE must be ignored.
    base = ss_falls;
    start_sweep();
    wait_falls(base + 3);
    repeat (40) @(negedge clk);
    strt_cnv = 1'b1;
    @(negedge clk) strt_cnv = 1'b0;
    wait_cnv();
    strt_cnv = 1'b1;
    @(negedge clk) strt_cnv = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("ignored_starts_txn_count", 32'(ss_falls - base), 32'd5);
    check("ignored_starts_busy", 32'(busy), 32'd0);

    // IR_lft changes; it must move only at the end of T3.
    adc_val[5] = 12'h055;
    start_sweep();
    wait_idle();

    // strt_cnv in the first IDLE cycle after DONE starts a new sweep.
    adc_val[0] = 12'h3A5;
    start_sweep();
    wait_cnv();
    @(negedge clk);
    adc_val[7] = 12'h1F0;
    push_sweep();
    strt_cnv = 1'b1;
    @(negedge clk) strt_cnv = 1'b0;
    check("back_to_back_busy", 32'(busy), 32'd1);
    wait_idle();

    // Reset in the middle of T2 aborts the sweep.
    set_spec_values();
    base = ss_falls;
    start_sweep();
    wait_falls(base + 3);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state("mid_sweep_reset");
    txn_q.delete();
    res_q.delete();
    for (int i = 0; i < 4; i++) mo[i] = 12'h000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check_reset_state("idle_after_abort");
    start_sweep();
    wait_idle();

    // Randomized sweeps.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      start_sweep();
      wait_idle();
    end

    repeat (10) @(negedge clk);
    check("final_res_queue", 32'(res_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/a2d_scheduler.md
A2D_SCHEDULER -- requirements
Module: a2d_scheduler

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- strt_cnv  in  1  one-cycle pulse that starts a 4-channel sweep.
- MISO  in  1  serial data from the ADC128S.
- SS_n  out  1  active-low slave select.
- SCLK  out  1  serial clock.
- MOSI  out  1  serial data to the ADC128S.
- batt  out  12  latest battery reading (ADC channel 0).
- IR_rght  out  12  latest right IR reading (channel 2).
- IR_lft  out  12  latest left IR reading (channel 5).
- IR_cntr  out  12  latest center IR reading (channel 7).
- busy  out  1  high while a sweep is in progress.
- cnv_cmplt  out  1  one-cycle pulse when a sweep finishes.

REQ-002 The block SHALL have one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-003 Command word SHALL be {2'b00, ch[2:0], 11'h000}, with ch occupying bits 13:11.

REQ-004 The ADC is pipelined: the result returned in transaction k belongs to the channel sent in transaction k-1.

REQ-005 A sweep SHALL be exactly 5 transactions, T0..T4.
- Channels sent: T0=0, T1=2, T2=5, T3=7, T4=7 (dummy).
- T0 received data SHALL be discarded.
- T1 result -> batt; T2 result -> IR_rght; T3 result -> IR_lft; T4 result -> IR_cntr.

REQ-006 Each result SHALL be the low 12 bits of the 16-bit word received; upper 4 bits are ignored.

REQ-007 Each result SHALL update its output register on the clk edge that ends its transaction; all other result outputs hold.

REQ-008 SCLK SHALL be bit 4 of a 5-bit divider counter, giving SCLK = clk/32.
- Counter preloads to 5'b10111 when SS_n falls.
- SCLK idles high.

REQ-009 Within a transaction:
- MOSI SHALL present cmd[15] from the cycle SS_n falls.
- MISO SHALL be sampled on the cycle the divider equals 5'b01111 (SCLK about to rise).
- The command shift register SHALL shift on the cycle the divider equals 5'b11111 (SCLK about to fall), except the first fall of the transaction.

REQ-010 After the 16th MISO sample, the next divider value 5'b11111 SHALL end the transaction.
- SS_n goes high on the following edge.
- No further SCLK fall occurs.
- SCLK stays high.

REQ-011 SS_n SHALL remain high for exactly 2 clk cycles between consecutive transactions of a sweep.

REQ-012 Controller states: IDLE, XFER, GAP, DONE.
- IDLE -> XFER on strt_cnv.
- XFER -> GAP at end of T0..T3.
- XFER -> DONE at end of T4.
- GAP -> XFER after 2 cycles, with the transaction index incremented.
- DONE -> IDLE after 1 cycle.

REQ-013 cnv_cmplt SHALL pulse high for exactly the one cycle spent in DONE; by then IR_cntr SHALL already hold the new value.

REQ-014 busy SHALL be high in XFER, GAP and DONE, and low in IDLE.

REQ-015 strt_cnv SHALL be ignored while busy is high, including in the DONE cycle; no sweep is queued.

REQ-016 strt_cnv arriving in the first IDLE cycle after DONE SHALL start a new sweep normally.

REQ-017 SS_n SHALL be high whenever the controller is in IDLE.

Reset
REQ-018 On rst the block SHALL asynchronously go to IDLE and force: SS_n=1, SCLK=1, MOSI=0, busy=0, cnv_cmplt=0, and batt, IR_rght, IR_lft, IR_cntr all 12'h000.

REQ-019 rst asserted mid-transaction SHALL abort the sweep immediately.
- SS_n rises with no further SCLK edges.
- Result registers clear to 12'h000.
- After rst deasserts, the block stays idle until the next strt_cnv.

Verification
REQ-020 The bench SHALL connect the ADC128S model with batt=12'hC00, IR_rght=12'h123, IR_lft=12'hABC, IR_cntr=12'h7E5, and cover these scenarios:
- Single strt_cnv -> exactly 5 SS_n-low windows of 16 SCLK falls each; cnv_cmplt pulses once; outputs read C00, 123, ABC, 7E5; the model prints no channel warning.
- Captured MOSI words -> 16'h0000, 16'h1000, 16'h2800, 16'h3800, 16'h3800 in order.
- Timing check -> SS_n-low window = 520 clk ±1; SS_n-high gap = 2 clk; SCLK period = 32 clk.
- strt_cnv pulsed again during T2 and during DONE -> ignored; still exactly 5 transactions, one cnv_cmplt.
- Change IR_lft to 12'h055 and start a second sweep -> IR_lft updates to 055 only at the end of T3; other outputs hold their values until their own slots.
- rst asserted mid-T2 -> SS_n=1 and SCLK=1 within the reset, outputs 000, busy=0; a subsequent strt_cnv completes a correct sweep.
